// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: FSM state encoding, NOP encoding and PC step.
package riscv_pkg;

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    REQ      = 2'd1,
    WAIT     = 2'd2,
    HOLD     = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: trap vector outranks redirect target, else sequential pc+4.
// Optional macro PC_FETCH_MISALIGN_CHECK_EN: a misaligned target is rejected and
// flagged instead of being loaded; without it the low two bits are cleared.
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            tgt_take,
  output logic [XLEN-1:0] tgt_pc,
  output logic [XLEN-1:0] seq_pc,
  output logic            misalign
);

  logic            req_any;
  logic [XLEN-1:0] raw_tgt;

  // Priority mux and target qualification.
  always_comb begin
    req_any = trap_req | redirect_valid;
    raw_tgt = trap_req ? trap_vec : redirect_pc;
    seq_pc  = pc + XLEN'(PC_INC);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    misalign = req_any && (raw_tgt[1:0] != 2'b00);
    tgt_take = req_any && !misalign;
    tgt_pc   = raw_tgt;
`else
    misalign = 1'b0;
    tgt_take = req_any;
    tgt_pc   = raw_tgt & ~XLEN'(3);
`endif
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, single-entry
// instruction buffer toward decode, redirect/trap handling with response kill.
// Optional macro PC_FETCH_MISALIGN_CHECK_EN (see pc_next_sel).
//
// state    | meaning
// RST_IDLE | first cycle after reset, pc may still be redirected
// REQ      | imem_req high with imem_addr = pc, waiting for grant
// WAIT     | request accepted, waiting for imem_rvalid (kill drops it)
// HOLD     | inst_valid high, waiting for dec_ready
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            dec_ready,
  output logic            pc_misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            kill_q, kill_d;
  logic            misalign_q;
  logic            cap_inst;

  logic            tgt_take;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] seq_pc;
  logic            misalign;

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .pc             (pc_q),
    .trap_req       (trap_req),
    .trap_vec       (trap_vec),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .tgt_take       (tgt_take),
    .tgt_pc         (tgt_pc),
    .seq_pc         (seq_pc),
    .misalign       (misalign)
  );

  // State, pc and instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_IDLE;
      pc_q       <= RESET_VECTOR;
      inst_q     <= NOP_INSN;
      inst_pc_q  <= '0;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign;
      if (cap_inst) begin
        inst_q    <= imem_rdata;
        inst_pc_q <= pc_q;
      end
    end
  end

  // Next-state, pc update and response kill decisions.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    cap_inst = 1'b0;
    case (state_q)
      RST_IDLE: begin
        state_d = REQ;
        if (tgt_take) pc_d = tgt_pc;
      end
      REQ: begin
        // a grant coinciding with a redirect is dropped; the new address is requested next
        if (tgt_take)      pc_d    = tgt_pc;
        else if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (tgt_take) pc_d = tgt_pc;
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (tgt_take || kill_q) begin
            state_d = REQ;
          end else begin
            cap_inst = 1'b1;
            state_d  = HOLD;
          end
        end else if (tgt_take) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (tgt_take) begin
          pc_d    = tgt_pc;
          state_d = REQ;
        end else if (dec_ready) begin
          pc_d    = seq_pc;
          state_d = REQ;
        end
      end
      default: state_d = RST_IDLE;
    endcase
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == HOLD);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: memory model, scoreboard of expected fetch flow,
// directed scenarios followed by a randomized phase.
module tb_pc_fetch_ctrl;
  import riscv_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vec = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready = 1'b0;
  logic        pc_misalign;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_req       (trap_req),
    .trap_vec       (trap_vec),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dec_ready      (dec_ready),
    .pc_misalign    (pc_misalign)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] raw_tgt();
    return trap_req ? trap_vec : redirect_pc;
  endfunction

  // Does the control flow change this cycle?
  function automatic logic redir_eff();
    logic [31:0] t;
    t = raw_tgt();
    if (!(trap_req || redirect_valid)) return 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    return t[1:0] == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] redir_tgt();
    return raw_tgt() & 32'hFFFF_FFFC;
  endfunction

  function automatic logic mis_now();
    logic [31:0] t;
    t = raw_tgt();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    return (trap_req || redirect_valid) && (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Memory model knobs.
  bit gnt_low = 0, gnt_rand = 0, lat_rand = 0, spur_en = 0;
  int mem_lat = 0;
  int resp_cnt = 0;

  // Memory: accept requests, answer after a latency, optionally emit stray responses.
  logic        acc_s;
  logic [31:0] acc_addr;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  always begin
    @(negedge clk);
    acc_s    = rst_n && imem_req && imem_gnt && !redir_eff();
    acc_addr = imem_addr;
    @(posedge clk);
    #2;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (acc_s) begin
      pend  = 1;
      paddr = acc_addr;
      cnt   = lat_rand ? $urandom_range(0, 3) : mem_lat;
    end
    if (pend && cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(paddr);
      pend        = 0;
      resp_cnt++;
    end else if (pend) begin
      cnt--;
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      imem_rvalid = 1'b1;
    end
    imem_gnt = gnt_low ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Scoreboard: exp_q[0] is the pc the next delivered instruction must carry.
  logic [31:0] exp_q[$];
  logic [31:0] xfer_pc_q[$];
  int          xfer_cyc_q[$];
  int          cyc = 0;
  logic        mis_exp = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_q.push_back(RV);
      mis_exp = 1'b0;
    end else begin
      if (pc_misalign || mis_exp) check("misalign_pulse", 32'(pc_misalign), 32'(mis_exp));
      if (imem_req && exp_q.size() > 0) check("fetch_addr", imem_addr, exp_q[0]);
      if (inst_valid && dec_ready && !redir_eff()) begin
        if (exp_q.size() == 0) begin
          check("unexpected_inst", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_word", inst, mem_word(e));
          exp_q.push_back(e + 32'd4);
        end
        xfer_pc_q.push_back(inst_pc);
        xfer_cyc_q.push_back(cyc);
      end
      if (redir_eff()) begin
        exp_q.delete();
        exp_q.push_back(redir_tgt());
      end
      mis_exp = mis_now();
    end
  end

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_xfer(input string name, output logic [31:0] pc_o);
    int n0;
    int k;
    n0 = xfer_pc_q.size();
    k  = 0;
    while (xfer_pc_q.size() == n0 && k < 60) begin
      neg();
      k++;
    end
    if (xfer_pc_q.size() == n0) begin
      $display("timeout waiting for instruction (%s)", name);
      pc_o = 32'hxxxx_xxxx;
    end else begin
      pc_o = xfer_pc_q[n0];
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RV);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, NOP_INSN);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_misalign"}, 32'(pc_misalign), 32'd0);
  endtask

  task automatic do_reset();
    pos();
    rst_n = 1'b0;
    pos();
    rst_n = 1'b1;
    xfer_pc_q.delete();
    xfer_cyc_q.delete();
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFF8;
    if (sel == 1) return (r & 32'h0000_0FFC) | 32'h1;
    return r & 32'h0000_0FFC;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] p;
    logic [31:0] old;
    int n;
    int k;
    int iv;

    rst_n = 1'b0;
    dec_ready = 1'b1;
    repeat (3) @(posedge clk);
    neg();
    check_reset("por");

    // Back-to-back sequential fetch with zero-wait memory.
    pos();
    rst_n = 1'b1;
    wait_xfer("seq0", p); check("seq0_pc", p, 32'h0);
    wait_xfer("seq1", p); check("seq1_pc", p, 32'h4);
    wait_xfer("seq2", p); check("seq2_pc", p, 32'h8);
    if (xfer_cyc_q.size() >= 3) begin
      check("seq_gap01", 32'(xfer_cyc_q[1] - xfer_cyc_q[0]), 32'd3);
      check("seq_gap12", 32'(xfer_cyc_q[2] - xfer_cyc_q[1]), 32'd3);
    end

    // Grant withheld for four cycles in REQ.
    do_reset();
    wait_xfer("hold0", p); check("hold0_pc", p, RV);
    gnt_low = 1;
    for (int i = 0; i < 4; i++) begin
      neg();
      check("gnt_low_req", 32'(imem_req), 32'd1);
      check("gnt_low_addr", imem_addr, 32'h4);
    end
    gnt_low = 0;
    wait_xfer("after_gnt", p); check("after_gnt_pc", p, 32'h4);

    // Redirect while waiting; response arrives the following cycle.
    mem_lat = 1;
    k = 0;
    neg();
    while (!(imem_req && imem_gnt) && k < 40) begin neg(); k++; end
    pos();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    pos();
    redirect_valid = 1'b0;
    neg();
    check("kill_wait_valid", 32'(inst_valid), 32'd0);
    check("kill_wait_req", 32'(imem_req), 32'd0);
    neg();
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_no_old", 32'(inst_valid), 32'd0);
    wait_xfer("redir_inst", p); check("redir_inst_pc", p, 32'h100);

    // Trap and redirect together while holding an instruction.
    mem_lat = 0;
    pos();
    dec_ready = 1'b0;
    k = 0;
    neg();
    while (!inst_valid && k < 40) begin neg(); k++; end
    pos();
    trap_req = 1'b1;       trap_vec = 32'h80;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    dec_ready = 1'b1;
    pos();
    trap_req = 1'b0;
    redirect_valid = 1'b0;
    neg();
    check("trap_drop_valid", 32'(inst_valid), 32'd0);
    check("trap_addr", imem_addr, 32'h80);
    wait_xfer("trap_inst", p); check("trap_inst_pc", p, 32'h80);

    // Misaligned redirect target.
    pos();
    gnt_low = 1;
    k = 0;
    neg();
    while (!imem_req && k < 40) begin neg(); k++; end
    old = imem_addr;
    pos();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    pos();
    redirect_valid = 1'b0;
    neg();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    check("mis_pulse", 32'(pc_misalign), 32'd1);
    check("mis_addr_kept", imem_addr, old);
`else
    check("mis_pulse", 32'(pc_misalign), 32'd0);
    check("mis_addr_forced", imem_addr, 32'h100);
`endif
    neg();
    check("mis_pulse_end", 32'(pc_misalign), 32'd0);
    gnt_low = 0;
    wait_xfer("mis_inst", p);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    check("mis_inst_pc", p, old);
`else
    check("mis_inst_pc", p, 32'h100);
`endif

    // Reset while a request is outstanding; its response arrives after release.
    mem_lat = 4;
    k = 0;
    neg();
    while (!(imem_req && imem_gnt) && k < 40) begin neg(); k++; end
    pos();
    rst_n   = 1'b0;
    gnt_low = 1;
    neg();
    check_reset("mid");
    n = resp_cnt;
    pos();
    rst_n = 1'b1;
    xfer_pc_q.delete();
    xfer_cyc_q.delete();
    iv = 0;
    k  = 0;
    while (resp_cnt == n && k < 20) begin
      neg();
      if (inst_valid) iv++;
      k++;
    end
    check("late_resp_seen", 32'(resp_cnt - n), 32'd1);
    neg();
    if (inst_valid) iv++;
    check("late_resp_ignored", 32'(iv), 32'd0);
    check("late_req_addr", imem_addr, RV);
    check("late_req_active", 32'(imem_req), 32'd1);
    mem_lat = 0;
    gnt_low = 0;
    wait_xfer("post_reset", p); check("post_reset_pc", p, RV);

    // Randomized traffic against the scoreboard.
    gnt_rand = 1;
    lat_rand = 1;
    spur_en  = 1;
    n = xfer_pc_q.size();
    for (int c = 0; c < 3000; c++) begin
      pos();
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      trap_req       = ($urandom_range(0, 31) == 0);
      redirect_pc    = rand_tgt();
      trap_vec       = rand_tgt();
    end
    pos();
    redirect_valid = 1'b0;
    trap_req       = 1'b0;
    repeat (4) neg();
    check("rand_progress", 32'(xfer_pc_q.size() - n > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports redirect_valid input 1 and redirect_pc input XLEN: taken branch/jump target from execute.
REQ-006 SHALL have ports trap_req input 1 and trap_vec input XLEN: exception entry, outranks redirect.
REQ-007 SHALL have ports imem_req output 1, imem_addr output XLEN, imem_gnt input 1: request phase, accepted when imem_req and imem_gnt are both high.
REQ-008 SHALL have ports imem_rvalid input 1 and imem_rdata input 32: response phase, one cycle per accepted request, in order.
REQ-009 SHALL have ports inst_valid output 1, inst output 32, inst_pc output XLEN, dec_ready input 1: instruction handshake to decode, transfer when inst_valid and dec_ready are both high.
REQ-010 SHALL have port pc_misalign output 1: one-cycle misaligned-target pulse (see Configuration).

Function
REQ-011 SHALL implement FSM states RST_IDLE, REQ, WAIT, HOLD.
REQ-012 RST_IDLE: one cycle after reset release, then REQ with pc = RESET_VECTOR.
REQ-013 REQ: imem_req=1, imem_addr=pc; on imem_gnt go to WAIT; imem_addr stable while ungranted.
REQ-014 WAIT: on imem_rvalid latch imem_rdata into inst, pc into inst_pc, go to HOLD; at most one request outstanding.
REQ-015 HOLD: inst_valid=1, inst/inst_pc stable; on dec_ready set pc = pc+4 (mod 2^XLEN, wrap silently), go to REQ.
REQ-016 Target selection priority: trap_req > redirect_valid > sequential pc+4.
REQ-017 Redirect/trap in REQ (granted or not): load target into pc, stay REQ next cycle with new address; a grant in that cycle is ignored.
REQ-018 Redirect/trap in WAIT: load target, set kill flag; matching imem_rvalid is discarded, then go to REQ.
REQ-019 Redirect/trap in WAIT coinciding with imem_rvalid: discard response, go to REQ with target.
REQ-020 Redirect/trap in HOLD: drop held instruction (inst_valid low next cycle) even if dec_ready same cycle, go to REQ with target.
REQ-021 Redirect/trap in RST_IDLE: pc loaded with target instead of RESET_VECTOR.
REQ-022 imem_rvalid outside WAIT SHALL be ignored.
REQ-023 Latency: sequential fetch with zero-wait memory = 3 cycles per instruction (REQ, WAIT, HOLD) with dec_ready held high.

Reset
REQ-024 Asserting rst_n low SHALL immediately force: state RST_IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0, kill=0, pc_misalign=0.
REQ-025 Reset mid-transaction SHALL abandon any outstanding request; post-reset responses ignored until a new grant.

Configuration
REQ-026 Macro PC_FETCH_MISALIGN_CHECK_EN defined: a redirect/trap target with bits [1:0] != 0 SHALL pulse pc_misalign for one cycle, not be loaded, and current flow continue.
REQ-027 Macro undefined: pc_misalign tied 0, target bits [1:0] forced to 0 on load.

Structure
REQ-028 Shared package riscv_pkg SHALL hold the FSM state typedef, NOP encoding 32'h0000_0013, PC increment 4.
REQ-029 Next-PC select (trap/redirect/pc+4) SHALL be sub-module pc_next_sel; rest in pc_fetch_ctrl.

Verification
REQ-030 Reset release, gnt=1, rvalid one cycle after grant, dec_ready=1 -> imem_addr 0x0,0x4,0x8; inst_pc matches; one instruction per 3 cycles.
REQ-031 gnt low 4 cycles in REQ -> imem_addr held at 0x4, no WAIT until gnt.
REQ-032 redirect_valid=1, redirect_pc=0x100 in WAIT, rvalid next cycle -> response dropped, next imem_addr=0x100, no inst_valid for old pc.
REQ-033 trap_req (vec 0x80) and redirect (0x200) same cycle in HOLD -> held instruction dropped, next imem_addr=0x80.
REQ-034 With macro, redirect_pc=0x102 -> pc_misalign one-cycle pulse, sequential fetch continues; without macro -> fetch at 0x100.
REQ-035 rst_n low while in WAIT, late rvalid after release -> ignored, first fetch at RESET_VECTOR, inst_valid=0 until its response.
